gyro_tilt_integrator: RTL and testbench
=======================================

Name: gyro_tilt_integrator

Overview:
- Consumes the three raw 16-bit signed angular-rate words (X, Y, Z) from the gyro SPI front end.
- Calibrates out the per-axis zero-rate bias at startup.
- Integrates the bias-corrected rates at a fixed sample rate into per-axis tilt-angle accumulators.
- Presents scaled, saturated 16-bit tilt angles to the downstream display/control logic.

Parameters:
- SAMPLE_DIV, 1000000: CLK cycles per integration sample (100 Hz at 100 MHz); must be >= 4.
- CAL_SHIFT, 6: calibration averages 2^CAL_SHIFT samples.
- DEADBAND, 16: corrected rates with |value| <= DEADBAND are treated as 0.
- ACC_W, 32: signed accumulator width per axis; must be >= 17 + OUT_SHIFT.
- OUT_SHIFT, 8: output angle = accumulator >>> OUT_SHIFT.

Ports:
- CLK  input  1  system clock
- RST  input  1  synchronous, active-high reset
- DX  input  16  signed raw X rate
- DY  input  16  signed raw Y rate
- DZ  input  16  signed raw Z rate
- ZERO  input  1  re-zero request (level sampled each cycle)
- X  output  16  signed X tilt angle
- Y  output  16  signed Y tilt angle
- Z  output  16  signed Z tilt angle
- CAL_DONE  output  1  high once the bias is latched
- UPDATE  output  1  one-cycle pulse when X/Y/Z change from a sample

Behaviour:
- One clock (CLK); RST is synchronous and active-high. All state is cleared on a CLK edge with RST=1.
- Reset values: X=Y=Z=0, CAL_DONE=0, UPDATE=0, accumulators=0, bias=0, cal sums=0, cal count=0, divider=0, state=CAL.
- Divider: counts 0..SAMPLE_DIV-1 then wraps to 0. The internal tick is high in the cycle where count==SAMPLE_DIV-1. The divider free-runs in both states.
- FSM states: CAL, RUN. There is no other state; RUN is left only via RST.
- CAL, on each tick:
  - Add the sign-extended DX/DY/DZ into (16+CAL_SHIFT)-bit sums; increment the cal count.
  - On the tick where count==2^CAL_SHIFT-1: bias = (sum + current sample) >>> CAL_SHIFT (arithmetic, truncating toward -inf).
  - Same edge: state->RUN, CAL_DONE->1.
  - UPDATE stays 0 throughout CAL; X/Y/Z stay 0.
- RUN, on tick (stage 1):
  - corr = DX - biasX, computed at 17 bits signed; same for Y and Z.
  - If |corr| <= DEADBAND, corr=0.
  - acc <= acc + sign-extended corr, saturating at ±(2^(ACC_W-1)) limits (min -2^(ACC_W-1), max 2^(ACC_W-1)-1).
- RUN, stage 2 (cycle after the tick):
  - X <= sat16(accX >>> OUT_SHIFT), clamped to [-32768, 32767]; same for Y and Z.
  - UPDATE <= 1 for exactly one cycle.
  - Latency: inputs sampled on the tick edge; new X/Y/Z and UPDATE are visible 2 edges after the tick.
- ZERO in RUN:
  - On the next edge, accumulators=0 and X/Y/Z=0; the stage-2 update for any in-flight sample is cancelled; UPDATE=0.
  - ZERO coincident with a tick: ZERO wins and the sample is discarded.
  - ZERO held high keeps outputs at 0.
- ZERO in CAL: ignored.
- RST mid-CAL or mid-RUN: full reset as above, then recalibration. An in-flight UPDATE is dropped.
- Inputs are sampled only on tick edges; changes between ticks have no effect.

Optional Feature:
- Macro: TILT_WRAP_EN.
- Defined: the accumulator add wraps modulo 2^ACC_W (no saturation). X/Y/Z are bits [OUT_SHIFT+15:OUT_SHIFT] of the accumulator with no clamping, so angles roll over continuously.
- Undefined: saturating accumulator and sat16 outputs as specified in Behaviour.

Test Plan:
All scenarios use SAMPLE_DIV=4, CAL_SHIFT=2, DEADBAND=16, ACC_W=24, OUT_SHIFT=8.
1. Reset, DX=100, DY=-40, DZ=0 held -> CAL_DONE rises on the 4th tick edge; biasX=100, biasY=-40; afterwards UPDATE pulses every 4 cycles with X=Y=Z=0.
2. Calibrate with all inputs 0, then DX=512 -> each UPDATE increments X by 2 (0, 2, 4, 6, ...); UPDATE appears 2 edges after each tick.
3. After zero-bias calibration: DX=16 for 10 ticks -> X stays 0. Then DX=-17 for 16 ticks -> accX=-272, X=-2 (arithmetic shift).
4. DX=32767 for 300 ticks -> accX saturates at 8388607 and holds, X=32767. With TILT_WRAP_EN: accX wraps and X goes negative after 256 ticks.
5. ZERO asserted in the same cycle as a tick with DX=512 -> next edge X=0; no UPDATE for that sample; the next tick yields X=2.
6. RST for 1 cycle while in RUN with X=10 -> X=Y=Z=0, CAL_DONE=0 next cycle; no UPDATE until recalibration completes 4 ticks later.

Source files
------------

// File: rtl/gyro_tilt_integrator.sv
// Three-axis gyro tilt integrator: startup bias calibration, deadbanded rate integration and
// 16-bit angle output. Define TILT_WRAP_EN for wrapping accumulators and unclamped angles.
module gyro_tilt_integrator #(
  parameter int unsigned SAMPLE_DIV = 1000000,
  parameter int unsigned CAL_SHIFT  = 6,
  parameter int unsigned DEADBAND   = 16,
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned OUT_SHIFT  = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic signed [15:0] DX,
  input  logic signed [15:0] DY,
  input  logic signed [15:0] DZ,
  input  logic               ZERO,
  output logic signed [15:0] X,
  output logic signed [15:0] Y,
  output logic signed [15:0] Z,
  output logic               CAL_DONE,
  output logic               UPDATE
);

  localparam int unsigned DivW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned SumW = 16 + CAL_SHIFT;
  localparam int unsigned CntW = (CAL_SHIFT > 0) ? CAL_SHIFT : 1;

  localparam logic [DivW-1:0]         DivLast = DivW'(SAMPLE_DIV - 1);
  localparam logic [CntW-1:0]         CalLast = CntW'((1 << CAL_SHIFT) - 1);
  localparam logic signed [16:0]      DbPos   = 17'(DEADBAND);
  localparam logic signed [16:0]      DbNeg   = -17'(DEADBAND);
`ifndef TILT_WRAP_EN
  localparam logic signed [ACC_W-1:0] AccMax  = {1'b0, {(ACC_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AccMin  = {1'b1, {(ACC_W - 1){1'b0}}};
  localparam logic signed [ACC_W-1:0] OutMax  = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] OutMin  = ACC_W'(-32768);
`endif

  typedef enum logic [0:0] {StCal, StRun} state_e;

  state_e state_q, state_d;

  logic [DivW-1:0] div_q, div_d;
  logic            tick;
  logic [CntW-1:0] cal_cnt_q;
  logic            pend_q;
  logic            update_q;
  logic            cal_tick, run_tick, run_zero, cal_last;

  logic signed [15:0]      raw       [3];
  logic signed [SumW-1:0]  cal_sum_q [3];
  logic signed [SumW-1:0]  sum_next  [3];
  logic signed [15:0]      bias_q    [3];
  logic signed [15:0]      bias_d    [3];
  logic signed [16:0]      corr      [3];
  logic signed [ACC_W-1:0] acc_q     [3];
  logic signed [ACC_W-1:0] acc_d     [3];
  logic signed [15:0]      out_q     [3];
  logic signed [15:0]      out_d     [3];
`ifndef TILT_WRAP_EN
  logic signed [ACC_W:0]   acc_wide  [3];
  logic signed [ACC_W-1:0] acc_shr   [3];
`endif

  assign raw[0] = DX;
  assign raw[1] = DY;
  assign raw[2] = DZ;

  assign tick  = (div_q == DivLast);
  assign div_d = tick ? '0 : div_q + DivW'(1);

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StCal;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: RUN is left only through reset
  always_comb begin
    state_d = state_q;
    if (state_q == StCal && tick && cal_tick && cal_last) begin
      state_d = StRun;
    end
  end

  // FSM outputs
  always_comb begin
    cal_tick = 1'b0;
    run_tick = 1'b0;
    run_zero = 1'b0;
    CAL_DONE = 1'b0;
    cal_last = (cal_cnt_q == CalLast);
    unique case (state_q)
      StCal: cal_tick = tick;
      StRun: begin
        CAL_DONE = 1'b1;
        run_zero = ZERO;
        run_tick = tick && !ZERO;
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      sum_next[i] = cal_sum_q[i] + SumW'(raw[i]);
      // Taking the bits above CAL_SHIFT is the floor-divide by 2^CAL_SHIFT
      bias_d[i]   = sum_next[i][CAL_SHIFT +: 16];
      corr[i]     = 17'(raw[i]) - 17'(bias_q[i]);
      if (corr[i] >= DbNeg && corr[i] <= DbPos) begin
        corr[i] = '0;
      end
`ifdef TILT_WRAP_EN
      acc_d[i] = acc_q[i] + ACC_W'(corr[i]);
      out_d[i] = acc_q[i][OUT_SHIFT +: 16];
`else
      acc_wide[i] = (ACC_W + 1)'(acc_q[i]) + (ACC_W + 1)'(corr[i]);
      if (acc_wide[i][ACC_W] != acc_wide[i][ACC_W-1]) begin
        acc_d[i] = acc_wide[i][ACC_W] ? AccMin : AccMax;
      end else begin
        acc_d[i] = acc_wide[i][ACC_W-1:0];
      end
      acc_shr[i] = acc_q[i] >>> OUT_SHIFT;
      if (acc_shr[i] > OutMax) begin
        out_d[i] = 16'sh7fff;
      end else if (acc_shr[i] < OutMin) begin
        out_d[i] = 16'sh8000;
      end else begin
        out_d[i] = acc_shr[i][15:0];
      end
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q     <= '0;
      cal_cnt_q <= '0;
      pend_q    <= 1'b0;
      update_q  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        cal_sum_q[i] <= '0;
        bias_q[i]    <= '0;
        acc_q[i]     <= '0;
        out_q[i]     <= '0;
      end
    end else begin
      div_q <= div_d;
      if (cal_tick) begin
        cal_cnt_q <= cal_cnt_q + CntW'(1);
        for (int i = 0; i < 3; i++) begin
          cal_sum_q[i] <= sum_next[i];
          if (cal_last) begin
            bias_q[i] <= bias_d[i];
          end
        end
      end
      // ZERO drops any sample in flight, including one arriving on this edge
      if (run_zero) begin
        pend_q   <= 1'b0;
        update_q <= 1'b0;
        for (int i = 0; i < 3; i++) begin
          acc_q[i] <= '0;
          out_q[i] <= '0;
        end
      end else begin
        pend_q   <= run_tick;
        update_q <= pend_q;
        for (int i = 0; i < 3; i++) begin
          if (run_tick) begin
            acc_q[i] <= acc_d[i];
          end
          if (pend_q) begin
            out_q[i] <= out_d[i];
          end
        end
      end
    end
  end

  assign X      = out_q[0];
  assign Y      = out_q[1];
  assign Z      = out_q[2];
  assign UPDATE = update_q;

endmodule

// File: tb/tb_gyro_tilt_integrator.sv
// Self-checking bench for gyro_tilt_integrator against an integer-arithmetic reference model.
module tb_gyro_tilt_integrator;

  localparam int DIV = 4;
  localparam int CAL_N = 4;
  localparam longint ACC_MAX = 64'sd8388607;
  localparam longint ACC_MIN = -64'sd8388608;

  logic               CLK;
  logic               RST;
  logic signed [15:0] DX, DY, DZ;
  logic               ZERO;
  logic signed [15:0] X, Y, Z;
  logic               CAL_DONE, UPDATE;

  int n_cmp = 0;
  int n_bad = 0;

  gyro_tilt_integrator #(
    .SAMPLE_DIV(4),
    .CAL_SHIFT (2),
    .DEADBAND  (16),
    .ACC_W     (24),
    .OUT_SHIFT (8)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .DX      (DX),
    .DY      (DY),
    .DZ      (DZ),
    .ZERO    (ZERO),
    .X       (X),
    .Y       (Y),
    .Z       (Z),
    .CAL_DONE(CAL_DONE),
    .UPDATE  (UPDATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  // Reference model state
  int     m_phase, m_ncal;
  bit     m_run, m_pend, m_upd, m_tick;
  longint m_sum[3], m_bias[3], m_acc[3], m_out[3];

  function automatic longint floordiv(longint a, longint b);
    longint q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint angle(longint acc);
    longint v;
    v = floordiv(acc, 256);
`ifdef TILT_WRAP_EN
    v = ((v % 65536) + 65536) % 65536;
    if (v >= 32768) v = v - 65536;
`else
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`endif
    return v;
  endfunction

  function automatic longint accumulate(longint acc, longint c);
    longint s;
    s = acc + c;
`ifdef TILT_WRAP_EN
    s = ((s % 16777216) + 16777216) % 16777216;
    if (s >= 8388608) s = s - 16777216;
`else
    if (s > ACC_MAX) s = ACC_MAX;
    if (s < ACC_MIN) s = ACC_MIN;
`endif
    return s;
  endfunction

  task automatic model_edge(input int dx, input int dy, input int dz, input bit zero,
                            input bit rst);
    longint d[3];
    longint c;
    d = '{dx, dy, dz};
    if (rst) begin
      m_phase = 0; m_ncal = 0; m_run = 0; m_pend = 0; m_upd = 0; m_tick = 0;
      for (int i = 0; i < 3; i++) begin
        m_sum[i] = 0; m_bias[i] = 0; m_acc[i] = 0; m_out[i] = 0;
      end
      return;
    end
    m_tick  = (m_phase == DIV - 1);
    m_phase = (m_phase + 1) % DIV;
    if (m_run) begin
      if (zero) begin
        m_pend = 0; m_upd = 0;
        for (int i = 0; i < 3; i++) begin
          m_acc[i] = 0; m_out[i] = 0;
        end
      end else begin
        m_upd = m_pend;
        if (m_pend) for (int i = 0; i < 3; i++) m_out[i] = angle(m_acc[i]);
        m_pend = m_tick;
        if (m_tick) begin
          for (int i = 0; i < 3; i++) begin
            c = d[i] - m_bias[i];
            if (c >= -16 && c <= 16) c = 0;
            m_acc[i] = accumulate(m_acc[i], c);
          end
        end
      end
    end else if (m_tick) begin
      for (int i = 0; i < 3; i++) m_sum[i] = m_sum[i] + d[i];
      m_ncal++;
      if (m_ncal == CAL_N) begin
        for (int i = 0; i < 3; i++) m_bias[i] = floordiv(m_sum[i], CAL_N);
        m_run = 1;
      end
    end
  endtask

  function automatic logic [49:0] exp_vec();
    return {16'(m_out[0]), 16'(m_out[1]), 16'(m_out[2]), m_upd, m_run};
  endfunction

  function automatic string got_str();
    return $sformatf("X=%0d Y=%0d Z=%0d UPD=%b DONE=%b", X, Y, Z, UPDATE, CAL_DONE);
  endfunction

  function automatic string exp_str();
    return $sformatf("X=%0d Y=%0d Z=%0d UPD=%b DONE=%b", 16'(m_out[0]), 16'(m_out[1]),
                     16'(m_out[2]), m_upd, m_run);
  endfunction

  task automatic cycle(input int dx, input int dy, input int dz, input bit zero, input bit rst);
    DX = 16'(dx); DY = 16'(dy); DZ = 16'(dz); ZERO = zero; RST = rst;
    @(posedge CLK);
    model_edge(dx, dy, dz, zero, rst);
    #1;
  endtask

  task automatic run_ticks(input int n, input int dx, input int dy, input int dz);
    int k = 0;
    while (k < n) begin
      cycle(dx, dy, dz, 1'b0, 1'b0);
      if (m_tick) k++;
    end
  endtask

  task automatic reset_and_cal(input int dx, input int dy, input int dz);
    cycle(dx, dy, dz, 1'b0, 1'b1);
    run_ticks(CAL_N, dx, dy, dz);
  endtask

  task automatic test_reset();
    cycle(int'($urandom_range(0, 60000)) - 30000, 7, -7, 1'b1, 1'b1);
    n_cmp++;
    if ({X, Y, Z, UPDATE, CAL_DONE} !== 50'd0) begin
      n_bad++;
      $display("FAIL reset_state: %s, required all zero", got_str());
    end
  endtask

  task automatic test_cal();
    int upd_cnt = 0;
    cycle(100, -40, 0, 1'b1, 1'b1);
    // ZERO held high during calibration must be ignored
    for (int i = 1; i <= 15; i++) cycle(100, -40, 0, 1'b1, 1'b0);
    n_cmp++;
    if (CAL_DONE !== 1'b0) begin
      n_bad++;
      $display("FAIL cal_early: CAL_DONE=%b, required 0", CAL_DONE);
    end
    cycle(100, -40, 0, 1'b0, 1'b0);
    n_cmp++;
    if (CAL_DONE !== 1'b1) begin
      n_bad++;
      $display("FAIL cal_done_4th_tick: CAL_DONE=%b, required 1", CAL_DONE);
    end
    for (int i = 0; i < 24; i++) begin
      cycle(100, -40, 0, 1'b0, 1'b0);
      upd_cnt += int'(UPDATE);
      n_cmp++;
      if ({X, Y, Z, UPDATE, CAL_DONE} !== exp_vec() || {X, Y, Z} !== 48'd0) begin
        n_bad++;
        $display("FAIL cal_bias_run: %s, required %s", got_str(), exp_str());
      end
    end
    n_cmp++;
    if (upd_cnt != 5) begin
      n_bad++;
      $display("FAIL cal_update_rate: %0d pulses, required 5", upd_cnt);
    end
  endtask

  task automatic test_integrate();
    int k = 0;
    reset_and_cal(0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      cycle(512, 0, 0, 1'b0, 1'b0);
      n_cmp++;
      if ({X, Y, Z, UPDATE, CAL_DONE} !== exp_vec()) begin
        n_bad++;
        $display("FAIL integrate_cycle: %s, required %s", got_str(), exp_str());
      end
      if (UPDATE === 1'b1) begin
        k++;
        n_cmp++;
        if (X !== 16'(2 * k)) begin
          n_bad++;
          $display("FAIL integrate_step: X=%0d, required %0d", X, 2 * k);
        end
      end
    end
    n_cmp++;
    if (k != 9) begin
      n_bad++;
      $display("FAIL integrate_updates: %0d pulses, required 9", k);
    end
  endtask

  task automatic test_deadband();
    reset_and_cal(0, 0, 0);
    run_ticks(10, 16, -16, 0);
    cycle(0, 0, 0, 1'b0, 1'b0);
    cycle(0, 0, 0, 1'b0, 1'b0);
    n_cmp++;
    if ({X, Y, Z} !== 48'd0) begin
      n_bad++;
      $display("FAIL deadband_edge: %s, required X=Y=Z=0", got_str());
    end
    run_ticks(16, -17, 17, -16);
    cycle(0, 0, 0, 1'b0, 1'b0);
    cycle(0, 0, 0, 1'b0, 1'b0);
    n_cmp++;
    if (X !== -16'sd2 || Y !== 16'sd1 || Z !== 16'sd0) begin
      n_bad++;
      $display("FAIL deadband_floor: %s, required X=-2 Y=1 Z=0", got_str());
    end
  endtask

  task automatic test_saturate();
    reset_and_cal(0, 0, 0);
    run_ticks(256, 32767, -32768, 0);
    cycle(0, 0, 0, 1'b0, 1'b0);
    cycle(0, 0, 0, 1'b0, 1'b0);
    n_cmp++;
    if (X !== 16'sd32767 || Y !== -16'sd32768) begin
      n_bad++;
      $display("FAIL sat_256: %s, required X=32767 Y=-32768", got_str());
    end
    run_ticks(44, 32767, -32768, 0);
    cycle(0, 0, 0, 1'b0, 1'b0);
    cycle(0, 0, 0, 1'b0, 1'b0);
    n_cmp++;
    if ({X, Y, Z, UPDATE, CAL_DONE} !== exp_vec()) begin
      n_bad++;
      $display("FAIL sat_300_model: %s, required %s", got_str(), exp_str());
    end
    n_cmp++;
`ifdef TILT_WRAP_EN
    if (X[15] !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_300: X=%0d, required negative", X);
    end
`else
    if (X !== 16'sd32767 || Y !== -16'sd32768) begin
      n_bad++;
      $display("FAIL sat_300: %s, required X=32767 Y=-32768", got_str());
    end
`endif
  endtask

  task automatic test_zero();
    reset_and_cal(0, 0, 0);
    run_ticks(3, 512, 0, 0);
    cycle(0, 0, 0, 1'b0, 1'b0);
    cycle(0, 0, 0, 1'b0, 1'b0);
    n_cmp++;
    if (X !== 16'sd6) begin
      n_bad++;
      $display("FAIL zero_pre: X=%0d, required 6", X);
    end
    while (m_phase != DIV - 1) cycle(0, 0, 0, 1'b0, 1'b0);
    cycle(512, 0, 0, 1'b1, 1'b0);
    n_cmp++;
    if (X !== 16'sd0 || UPDATE !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_on_tick: %s, required X=0 UPD=0", got_str());
    end
    cycle(0, 0, 0, 1'b0, 1'b0);
    n_cmp++;
    if (X !== 16'sd0 || UPDATE !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_no_update: %s, required X=0 UPD=0", got_str());
    end
    run_ticks(1, 512, 0, 0);
    cycle(0, 0, 0, 1'b0, 1'b0);
    n_cmp++;
    if (X !== 16'sd2 || UPDATE !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_next_tick: %s, required X=2 UPD=1", got_str());
    end
    for (int i = 0; i < 12; i++) begin
      cycle(30000, 30000, -30000, 1'b1, 1'b0);
      n_cmp++;
      if ({X, Y, Z, UPDATE} !== 49'd0) begin
        n_bad++;
        $display("FAIL zero_held: %s, required all zero", got_str());
      end
    end
  endtask

  task automatic test_reset_run();
    int upd_cnt = 0;
    reset_and_cal(0, 0, 0);
    run_ticks(5, 512, 0, 0);
    cycle(0, 0, 0, 1'b0, 1'b0);
    cycle(0, 0, 0, 1'b0, 1'b0);
    n_cmp++;
    if (X !== 16'sd10) begin
      n_bad++;
      $display("FAIL rst_pre: X=%0d, required 10", X);
    end
    run_ticks(1, 512, 0, 0);
    cycle(512, 0, 0, 1'b0, 1'b1);
    n_cmp++;
    if ({X, Y, Z, UPDATE, CAL_DONE} !== 50'd0) begin
      n_bad++;
      $display("FAIL rst_in_run: %s, required all zero", got_str());
    end
    for (int i = 0; i < 20; i++) begin
      cycle(512, 0, 0, 1'b0, 1'b0);
      upd_cnt += int'(UPDATE);
      n_cmp++;
      if ({X, Y, Z, UPDATE, CAL_DONE} !== exp_vec()) begin
        n_bad++;
        $display("FAIL rst_recal: %s, required %s", got_str(), exp_str());
      end
    end
    n_cmp++;
    if (upd_cnt != 0 || CAL_DONE !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_recal_end: %0d pulses DONE=%b, required 0 pulses DONE=1", upd_cnt,
               CAL_DONE);
    end
  endtask

  task automatic test_random();
    int base[3];
    int d[3];
    logic signed [15:0] r;
    for (int round = 0; round < 4; round++) begin
      for (int a = 0; a < 3; a++) base[a] = int'($urandom_range(0, 4000)) - 2000;
      for (int n = 0; n < 600; n++) begin
        for (int a = 0; a < 3; a++) begin
          if ($urandom_range(0, 15) == 0) begin
            r = 16'($urandom);
            d[a] = r;
          end else begin
            d[a] = base[a] + int'($urandom_range(0, 100)) - 50;
          end
        end
        cycle(d[0], d[1], d[2], $urandom_range(0, 39) == 0,
              n == 0 || $urandom_range(0, 499) == 0);
        n_cmp++;
        if ({X, Y, Z, UPDATE, CAL_DONE} !== exp_vec()) begin
          n_bad++;
          $display("FAIL random_r%0d_c%0d: %s, required %s", round, n, got_str(), exp_str());
        end
      end
    end
  endtask

  initial begin
    RST = 1'b1; ZERO = 1'b0; DX = '0; DY = '0; DZ = '0;
    test_reset();
    test_cal();
    test_integrate();
    test_deadband();
    test_saturate();
    test_zero();
    test_reset_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
